// File: rtl/axis_stall_block_detector_if.sv
// Per-channel AXI-Stream handshake bundle observed by the stall/block detector.
// The master side drives TVALID/TREADY; the detector only listens on the slave side.
interface axis_stall_block_detector_if #(
  parameter int N_CH = 3
);
  logic [N_CH-1:0] axis_tvalid;
  logic [N_CH-1:0] axis_tready;

  modport master (
    output axis_tvalid,
    output axis_tready
  );

  modport slave (
    input axis_tvalid,
    input axis_tready
  );
endinterface

// File: rtl/axis_stall_block_detector.sv
// Flags per-channel AXI-Stream stalls as full/empty blocks after STALL_THRESH cycles and records the first one.
// Block bits rise at the edge that samples the STALL_THRESH-th stall; the monitor is passive and never backpressures.
module axis_stall_block_detector #(
  parameter int N_CH         = 3,
  parameter int CNT_W        = 5,
  parameter int STALL_THRESH = 16,
  parameter int IDX_W        = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  axis_stall_block_detector_if.slave  axis,
  input  logic                        inst_idle,
  input  logic                        clear_first,
  output logic [N_CH-1:0]             axis_block_sigs,
  output logic [N_CH-1:0]             block_full,
  output logic [N_CH-1:0]             block_empty,
  output logic                        any_block,
  output logic                        first_block_vld,
  output logic [IDX_W-1:0]            first_block_idx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL_F = 2'd1,
    STALL_E = 2'd2
  } stall_state_t;

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  stall_state_t     state_q [N_CH];
  stall_state_t     state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];

  logic [N_CH-1:0]  stall_f;
  logic [N_CH-1:0]  stall_e;
  logic [N_CH-1:0]  next_full;
  logic [N_CH-1:0]  next_empty;
  logic [N_CH-1:0]  next_block;
  logic [IDX_W-1:0] low_idx;

  // An idle instance legitimately has nothing to offer, so starvation is masked.
  assign stall_f = axis.axis_tvalid & ~axis.axis_tready;
  assign stall_e = axis.axis_tready & ~axis.axis_tvalid & {N_CH{~inst_idle}};

  always_comb begin
    next_full  = '0;
    next_empty = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      case (state_q[ch])
        IDLE: begin
          if (stall_f[ch]) begin
            state_d[ch] = STALL_F;
            cnt_d[ch]   = ONE;
          end else if (stall_e[ch]) begin
            state_d[ch] = STALL_E;
            cnt_d[ch]   = ONE;
          end else begin
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
          end
        end
        STALL_F: begin
          if (stall_f[ch]) begin
            cnt_d[ch] = (cnt_q[ch] == THRESH) ? cnt_q[ch] : cnt_q[ch] + ONE;
          end else if (stall_e[ch]) begin
            state_d[ch] = STALL_E;
            cnt_d[ch]   = ONE;
          end else begin
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
          end
        end
        STALL_E: begin
          if (stall_e[ch]) begin
            cnt_d[ch] = (cnt_q[ch] == THRESH) ? cnt_q[ch] : cnt_q[ch] + ONE;
          end else if (stall_f[ch]) begin
            state_d[ch] = STALL_F;
            cnt_d[ch]   = ONE;
          end else begin
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
          end
        end
        default: begin
          state_d[ch] = IDLE;
          cnt_d[ch]   = '0;
        end
      endcase
      next_full[ch]  = (state_d[ch] == STALL_F) && (cnt_d[ch] == THRESH);
      next_empty[ch] = (state_d[ch] == STALL_E) && (cnt_d[ch] == THRESH);
    end
  end

  assign next_block = next_full | next_empty;

  // Descending scan so the lowest blocked channel is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (next_block[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
      end
      block_full      <= '0;
      block_empty     <= '0;
      axis_block_sigs <= '0;
      any_block       <= 1'b0;
      first_block_vld <= 1'b0;
      first_block_idx <= '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      block_full      <= next_full;
      block_empty     <= next_empty;
      axis_block_sigs <= next_block;
      any_block       <= |next_block;
      if (clear_first) begin
        first_block_vld <= 1'b0;
        first_block_idx <= '0;
      end else if (!first_block_vld && (|next_block)) begin
        first_block_vld <= 1'b1;
        first_block_idx <= low_idx;
      end
    end
  end

endmodule

// File: tb/tb_axis_stall_block_detector.sv
// Directed bench for axis_stall_block_detector with hand-computed expectations (THRESH=16, 3 channels).
module tb_axis_stall_block_detector;

  logic       clock;
  logic       reset;
  logic       inst_idle;
  logic       clear_first;
  logic [2:0] axis_block_sigs;
  logic [2:0] block_full;
  logic [2:0] block_empty;
  logic       any_block;
  logic       first_block_vld;
  logic [1:0] first_block_idx;

  int n_checks = 0;
  int n_fail   = 0;

  axis_stall_block_detector_if #(.N_CH(3)) axis_if ();

  axis_stall_block_detector #(
    .N_CH(3), .CNT_W(5), .STALL_THRESH(16), .IDX_W(2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis            (axis_if.slave),
    .inst_idle       (inst_idle),
    .clear_first     (clear_first),
    .axis_block_sigs (axis_block_sigs),
    .block_full      (block_full),
    .block_empty     (block_empty),
    .any_block       (any_block),
    .first_block_vld (first_block_vld),
    .first_block_idx (first_block_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] full, input logic [2:0] empty,
                            input logic vld, input logic [1:0] idx);
    check_eq({tag, ".full"},  32'(block_full),      32'(full));
    check_eq({tag, ".empty"}, 32'(block_empty),     32'(empty));
    check_eq({tag, ".sigs"},  32'(axis_block_sigs), 32'(full | empty));
    check_eq({tag, ".any"},   32'(any_block),       32'(|(full | empty)));
    check_eq({tag, ".vld"},   32'(first_block_vld), 32'(vld));
    check_eq({tag, ".idx"},   32'(first_block_idx), 32'(idx));
  endtask

  task automatic pulse_clear();
    clear_first = 1'b1;
    tick(1);
    clear_first = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    inst_idle            = 1'b0;
    clear_first          = 1'b0;
    axis_if.axis_tvalid  = 3'b000;
    axis_if.axis_tready  = 3'b000;
    tick(2);
    check_outs("reset", 3'b000, 3'b000, 1'b0, 2'd0);
    #3 reset = 1'b0;
    tick(1);

    // 1: full stall on ch0, block on edge 16 not 15
    axis_if.axis_tvalid = 3'b001;
    tick(15);
    check_outs("t1_edge15", 3'b000, 3'b000, 1'b0, 2'd0);
    tick(1);
    check_outs("t1_edge16", 3'b001, 3'b000, 1'b1, 2'd0);
    axis_if.axis_tvalid = 3'b000;
    tick(1);
    check_outs("t1_release", 3'b000, 3'b000, 1'b1, 2'd0);
    pulse_clear();
    check_outs("t1_clear", 3'b000, 3'b000, 1'b0, 2'd0);

    // 2: empty stall on ch1 masked by inst_idle
    inst_idle = 1'b1;
    axis_if.axis_tready = 3'b010;
    tick(20);
    check_outs("t2_idle", 3'b000, 3'b000, 1'b0, 2'd0);
    inst_idle = 1'b0;
    tick(15);
    check_outs("t2_edge15", 3'b000, 3'b000, 1'b0, 2'd0);
    tick(1);
    check_outs("t2_edge16", 3'b000, 3'b010, 1'b1, 2'd1);
    axis_if.axis_tready = 3'b000;
    tick(1);
    pulse_clear();
    check_outs("t2_clear", 3'b000, 3'b000, 1'b0, 2'd0);

    // 3: handshake in the middle of a ch2 stall restarts the count
    axis_if.axis_tvalid = 3'b100;
    tick(10);
    axis_if.axis_tready = 3'b100;
    tick(1);
    axis_if.axis_tready = 3'b000;
    tick(10);
    check_outs("t3_restart", 3'b000, 3'b000, 1'b0, 2'd0);
    axis_if.axis_tvalid = 3'b000;
    tick(1);

    // 4: ch2 full and ch1 empty reach threshold together; lowest index wins
    axis_if.axis_tvalid = 3'b100;
    axis_if.axis_tready = 3'b010;
    tick(16);
    check_outs("t4_both", 3'b100, 3'b010, 1'b1, 2'd1);
    pulse_clear();
    check_outs("t4_clear", 3'b100, 3'b010, 1'b0, 2'd0);
    tick(1);
    check_outs("t4_relatch", 3'b100, 3'b010, 1'b1, 2'd1);
    axis_if.axis_tvalid = 3'b000;
    axis_if.axis_tready = 3'b000;
    tick(1);
    pulse_clear();
    check_outs("t4_idle", 3'b000, 3'b000, 1'b0, 2'd0);

    // 5: long ch0 stall saturates; F->E change drops block then re-blocks as empty
    axis_if.axis_tvalid = 3'b001;
    tick(16);
    check_outs("t5_edge16", 3'b001, 3'b000, 1'b1, 2'd0);
    tick(84);
    check_outs("t5_edge100", 3'b001, 3'b000, 1'b1, 2'd0);
    axis_if.axis_tvalid = 3'b000;
    axis_if.axis_tready = 3'b001;
    tick(1);
    check_outs("t5_switch", 3'b000, 3'b000, 1'b1, 2'd0);
    tick(14);
    check_outs("t5_e15", 3'b000, 3'b000, 1'b1, 2'd0);
    tick(1);
    check_outs("t5_e16", 3'b000, 3'b001, 1'b1, 2'd0);

    // 6: async reset mid-block clears outputs before the next edge; count restarts
    tick(2);
    check_outs("t6_pre", 3'b000, 3'b001, 1'b1, 2'd0);
    #2 reset = 1'b1;
    #1;
    check_outs("t6_async", 3'b000, 3'b000, 1'b0, 2'd0);
    #2 reset = 1'b0;
    tick(15);
    check_outs("t6_edge15", 3'b000, 3'b000, 1'b0, 2'd0);
    tick(1);
    check_outs("t6_edge16", 3'b000, 3'b001, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
